// File: rtl/dual_rail_phase_sequencer_if.sv
// dual_rail_phase_sequencer_if: command/response handshake plus the dual-rail controller bus.
//   cmd_valid/cmd_ready/cmd_rd/cmd_ld : single-rail command handshake from the requester
//   rsp_valid/rsp_rc/rsp_rm/rsp_err   : one-cycle response pulse with held result bits
//   busy                              : sequencer is inside a command
//   PH0/PH1/Rd/Ld (_t/_f)             : dual-rail drive rails toward the controller
//   R_c/R_m (_t/_f)                   : dual-rail completion rails returned by the controller
//   master modport is the sequencer side, slave modport is the requester/controller side.
interface dual_rail_phase_sequencer_if;
   logic cmd_valid, cmd_ready, cmd_rd, cmd_ld;
   logic rsp_valid, rsp_rc, rsp_rm, rsp_err, busy;
   logic PH0_t, PH0_f, PH1_t, PH1_f, Rd_t, Rd_f, Ld_t, Ld_f;
   logic R_c_t, R_c_f, R_m_t, R_m_f;
   modport master (
      input  cmd_valid, cmd_rd, cmd_ld, R_c_t, R_c_f, R_m_t, R_m_f,
      output cmd_ready, rsp_valid, rsp_rc, rsp_rm, rsp_err, busy,
      output PH0_t, PH0_f, PH1_t, PH1_f, Rd_t, Rd_f, Ld_t, Ld_f
   );
   modport slave (
      output cmd_valid, cmd_rd, cmd_ld, R_c_t, R_c_f, R_m_t, R_m_f,
      input  cmd_ready, rsp_valid, rsp_rc, rsp_rm, rsp_err, busy,
      input  PH0_t, PH0_f, PH1_t, PH1_f, Rd_t, Rd_f, Ld_t, Ld_f
   );
endinterface

// File: rtl/dual_rail_phase_sequencer.sv
// dual_rail_phase_sequencer: drives DATA/NULL wavefronts into a NULL-convention controller per command.
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : dual_rail_phase_sequencer_if.master (command handshake, response, busy, drive and return rails)
//   SYNC_STAGES : flop stages on the returned rails (>= 2)
//   TIMEOUT     : cycles allowed per wavefront state before forcing ERR
//   TO_W        : width of the timeout counter
module dual_rail_phase_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 64,
   parameter int TO_W        = 7
) (
   input logic                         clk,
   input logic                         rst,
   dual_rail_phase_sequencer_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_D0, S_N0, S_D1, S_N1, S_ERR} state_t;
   state_t r_state, w_next;
   logic [SYNC_STAGES-1:0][3:0] r_sync;
   logic [TO_W-1:0] r_cnt;
   logic [7:0] r_drv, w_drv;
   logic [3:0] w_rs, w_data;
   logic r_rd, r_ld, r_cap_rc, r_cap_rm;
   logic r_rsp_valid, r_rsp_rc, r_rsp_rm, r_rsp_err;
   logic w_complete, w_nulled, w_illegal, w_accept, w_wave, w_to, w_rd, w_ld;
   // w_rs = {R_c_t, R_c_f, R_m_t, R_m_f} after the synchronizer
   assign w_rs       = r_sync[SYNC_STAGES-1];
   assign w_illegal  = (w_rs[3] & w_rs[2]) | (w_rs[1] & w_rs[0]);
   assign w_complete = (w_rs[3] ^ w_rs[2]) & (w_rs[1] ^ w_rs[0]);
   assign w_nulled   = w_rs == 4'b0000;
   assign w_accept   = bus.cmd_valid & bus.cmd_ready;
   assign w_wave     = r_state inside {S_D0, S_N0, S_D1, S_N1};
   // the state is on its TIMEOUT-th cycle; leaving without the awaited condition means ERR
   assign w_to       = w_wave && (r_cnt == TO_W'(TIMEOUT - 1));
   // command bits as they will be latched after this edge, so the rails can be registered from next state
   assign w_rd       = w_accept ? bus.cmd_rd : r_rd;
   assign w_ld       = w_accept ? bus.cmd_ld : r_ld;
   assign w_data     = {w_rd, ~w_rd, w_ld, ~w_ld};
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_accept ? S_D0 : S_IDLE;
         // phase 0 must answer R_c=0, R_m=1; any other complete code is a controller fault
         S_D0:    w_next = w_illegal ? S_ERR : w_complete ? ((w_rs == 4'b0110) ? S_N0 : S_ERR) : w_to ? S_ERR : S_D0;
         S_N0:    w_next = w_illegal ? S_ERR : w_nulled ? S_D1 : w_to ? S_ERR : S_N0;
         S_D1:    w_next = w_illegal ? S_ERR : w_complete ? S_N1 : w_to ? S_ERR : S_D1;
         S_N1:    w_next = w_illegal ? S_ERR : w_nulled ? S_IDLE : w_to ? S_ERR : S_N1;
         S_ERR:   w_next = w_nulled ? S_IDLE : S_ERR;
         default: w_next = S_IDLE;
      endcase
   end
   // rail order {PH0_t, PH0_f, PH1_t, PH1_f, Rd_t, Rd_f, Ld_t, Ld_f}; every other state is NULL
   assign w_drv = (w_next == S_D0) ? {4'b1001, w_data} :
                  (w_next == S_D1) ? {4'b0110, w_data} : 8'h00;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_sync      <= '0;
         r_cnt       <= '0;
         r_drv       <= '0;
         r_rd        <= 1'b0;
         r_ld        <= 1'b0;
         r_cap_rc    <= 1'b0;
         r_cap_rm    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rc    <= 1'b0;
         r_rsp_rm    <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_sync      <= {r_sync[SYNC_STAGES-2:0], {bus.R_c_t, bus.R_c_f, bus.R_m_t, bus.R_m_f}};
         r_cnt       <= (w_next != r_state || !w_wave) ? '0 : r_cnt + 1'b1;
         r_drv       <= w_drv;
         r_rd        <= w_rd;
         r_ld        <= w_ld;
         r_rsp_valid <= (r_state == S_N1 || r_state == S_ERR) && w_next == S_IDLE;
         if (r_state == S_D1 && w_next == S_N1) begin
            r_cap_rc <= w_rs[3];
            r_cap_rm <= w_rs[1];
         end
         // result bits are published only with the pulse so they stay stable between responses
         if (r_state == S_N1 && w_next == S_IDLE) begin
            r_rsp_rc  <= r_cap_rc;
            r_rsp_rm  <= r_cap_rm;
            r_rsp_err <= 1'b0;
         end else if (r_state == S_ERR && w_next == S_IDLE) begin
            r_rsp_rc  <= 1'b0;
            r_rsp_rm  <= 1'b0;
            r_rsp_err <= 1'b1;
         end
      end
   end
   assign bus.cmd_ready = (r_state == S_IDLE) & ~rst;
   assign bus.busy      = r_state != S_IDLE;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rc    = r_rsp_rc;
   assign bus.rsp_rm    = r_rsp_rm;
   assign bus.rsp_err   = r_rsp_err;
   assign {bus.PH0_t, bus.PH0_f, bus.PH1_t, bus.PH1_f, bus.Rd_t, bus.Rd_f, bus.Ld_t, bus.Ld_f} = r_drv;
endmodule

// File: tb/tb_dual_rail_phase_sequencer.sv
// tb_dual_rail_phase_sequencer: randomized and directed checks of the sequencer against a behavioural controller model.
module tb_dual_rail_phase_sequencer;
   localparam int S   = 2;
   localparam int TO  = 8;
   // each of the four wavefronts lasts S+1 cycles with an ideal controller, response in the following cycle
   localparam int LAT = 4 * (S + 1) + 1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   viol = 0;
   int   mode = 0;
   logic inj = 1'b0;
   logic [1:0] cmd_q[$];
   int         acc_q[$];
   int         rsp_t[$];
   logic [2:0] rsp_v[$];
   logic [7:0] rails;
   logic [3:0] w_r;
   dual_rail_phase_sequencer_if b ();
   dual_rail_phase_sequencer #(.SYNC_STAGES(S), .TIMEOUT(TO), .TO_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (b.master)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign rails = {b.PH0_t, b.PH0_f, b.PH1_t, b.PH1_f, b.Rd_t, b.Rd_f, b.Ld_t, b.Ld_f};
   // controller: phase 0 answers (R_c,R_m)=(0,1), phase 1 answers (Rd,Ld); NULL in, NULL out
   // mode 1: phase 0 answers R_c=1; mode 2: phase 1 never completes; inj forces R_m to 11
   always_comb begin
      w_r = 4'b0000;
      if (b.PH0_t && !b.PH0_f) w_r = (mode == 1) ? 4'b1010 : 4'b0110;
      else if (b.PH1_t && !b.PH1_f) w_r = (mode == 2) ? 4'b0000 : {b.Rd_t, b.Rd_f, b.Ld_t, b.Ld_f};
      if (inj) w_r[1:0] = 2'b11;
      {b.R_c_t, b.R_c_f, b.R_m_t, b.R_m_f} = w_r;
   end
   always @(negedge clk)
      if ((b.PH0_t & b.PH0_f) | (b.PH1_t & b.PH1_f) | (b.Rd_t & b.Rd_f) | (b.Ld_t & b.Ld_f)) viol++;
   initial begin
      #600000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end
   task automatic accept_one(input logic rd, input logic ld, output int t);
      t = -1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         b.cmd_valid = 1'b1;
         b.cmd_rd    = rd;
         b.cmd_ld    = ld;
         #1;
         if (b.cmd_ready) begin
            t = cyc + 1;
            break;
         end
      end
   endtask
   task automatic watch(input int t0, input int budget, input int inj_on, input int inj_off,
                        output int t_rsp, output logic [2:0] v, output int ph1_n, output int drv_n);
      t_rsp = -1;
      v     = 3'b000;
      ph1_n = 0;
      drv_n = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         b.cmd_valid = 1'b0;
         b.cmd_rd    = 1'($urandom);
         b.cmd_ld    = 1'($urandom);
         if (cyc + 1 == t0 + inj_on) inj = 1'b1;
         if (cyc + 1 == t0 + inj_off) inj = 1'b0;
         if (b.PH1_t) ph1_n++;
         if (rails != 8'h00) drv_n++;
         if (b.rsp_valid) begin
            t_rsp = cyc + 1;
            v     = {b.rsp_rc, b.rsp_rm, b.rsp_err};
            break;
         end
      end
      inj = 1'b0;
   endtask
   task automatic drive_stream(input int gap_max, input int budget);
      int idx = 0;
      int gap = 0;
      acc_q.delete();
      rsp_t.delete();
      rsp_v.delete();
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (b.rsp_valid) begin
            rsp_t.push_back(cyc + 1);
            rsp_v.push_back({b.rsp_rc, b.rsp_rm, b.rsp_err});
         end
         if (idx < cmd_q.size() && gap == 0) begin
            b.cmd_valid = 1'b1;
            {b.cmd_rd, b.cmd_ld} = cmd_q[idx];
         end else begin
            b.cmd_valid = 1'b0;
            {b.cmd_rd, b.cmd_ld} = 2'($urandom);
            if (gap > 0 && b.cmd_ready) gap--;
         end
         #1;
         if (b.cmd_valid && b.cmd_ready) begin
            acc_q.push_back(cyc + 1);
            idx++;
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         end
         if (idx == cmd_q.size() && rsp_t.size() >= cmd_q.size()) break;
      end
      b.cmd_valid = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (rails !== 8'h00) begin bad++; $display("FAIL reset_rails got=%b want=%b", rails, 8'h00); end
      total++; if (b.cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", b.cmd_ready); end
      total++; if (b.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", b.busy); end
      total++; if ({b.rsp_valid, b.rsp_rc, b.rsp_rm, b.rsp_err} !== 4'b0000) begin
         bad++; $display("FAIL reset_rsp got=%b want=0000", {b.rsp_valid, b.rsp_rc, b.rsp_rm, b.rsp_err});
      end
      rst = 1'b0;
      #1;
      total++; if (b.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", b.cmd_ready); end
   endtask
   task automatic test_basic();
      int t, tr, p1, dn;
      logic [2:0] v;
      mode = 0;
      accept_one(1'b1, 1'b0, t);
      total++; if (t < 0) begin bad++; $display("FAIL basic_accept got=none want=accept"); end
      @(negedge clk);
      b.cmd_valid = 1'b0;
      b.cmd_rd    = 1'b0;
      b.cmd_ld    = 1'b1;
      total++; if (rails !== 8'b1001_1001) begin bad++; $display("FAIL basic_d0_rails got=%b want=%b", rails, 8'b1001_1001); end
      total++; if (b.busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", b.busy); end
      watch(t, 40, -1, -1, tr, v, p1, dn);
      total++; if (tr !== t + LAT) begin bad++; $display("FAIL basic_rsp_time got=%0d want=%0d", tr, t + LAT); end
      total++; if (v !== 3'b100) begin bad++; $display("FAIL basic_rsp got=%b want=100", v); end
      total++; if (p1 !== S + 1) begin bad++; $display("FAIL basic_d1_len got=%0d want=%0d", p1, S + 1); end
      total++; if (b.cmd_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_at_rsp got=%b want=1", b.cmd_ready); end
   endtask
   task automatic test_back_to_back();
      mode = 0;
      viol = 0;
      cmd_q = '{2'b00, 2'b01, 2'b11};
      drive_stream(0, 80);
      total++; if (rsp_t.size() !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", rsp_t.size()); end
      for (int i = 0; i < 3 && i < rsp_t.size() && acc_q.size() > 0; i++) begin
         total++; if (rsp_t[i] !== acc_q[0] + LAT * (i + 1)) begin
            bad++; $display("FAIL b2b_time[%0d] got=%0d want=%0d", i, rsp_t[i], acc_q[0] + LAT * (i + 1));
         end
         total++; if (rsp_v[i] !== {cmd_q[i], 1'b0}) begin
            bad++; $display("FAIL b2b_rsp[%0d] got=%b want=%b", i, rsp_v[i], {cmd_q[i], 1'b0});
         end
      end
      total++; if (viol !== 0) begin bad++; $display("FAIL b2b_rail_11 got=%0d want=0", viol); end
   endtask
   task automatic test_bad_phase0();
      int t, tr, p1, dn;
      logic [2:0] v;
      mode = 1;
      accept_one(1'b1, 1'b1, t);
      watch(t, 40, -1, -1, tr, v, p1, dn);
      total++; if (tr !== t + 2 * (S + 1) + 1) begin bad++; $display("FAIL bad_p0_time got=%0d want=%0d", tr, t + 2 * (S + 1) + 1); end
      total++; if (v !== 3'b001) begin bad++; $display("FAIL bad_p0_rsp got=%b want=001", v); end
      total++; if (p1 !== 0 || dn !== S + 1) begin bad++; $display("FAIL bad_p0_rails got=ph1:%0d drv:%0d want=ph1:0 drv:%0d", p1, dn, S + 1); end
      mode = 0;
   endtask
   task automatic test_timeout();
      int t, tr, p1, dn;
      logic [2:0] v;
      mode = 2;
      accept_one(1'b0, 1'b1, t);
      watch(t, 60, -1, -1, tr, v, p1, dn);
      total++; if (p1 !== TO) begin bad++; $display("FAIL timeout_d1_len got=%0d want=%0d", p1, TO); end
      total++; if (tr !== t + 2 * (S + 1) + TO + 2) begin bad++; $display("FAIL timeout_time got=%0d want=%0d", tr, t + 2 * (S + 1) + TO + 2); end
      total++; if (v !== 3'b001) begin bad++; $display("FAIL timeout_rsp got=%b want=001", v); end
      mode = 0;
   endtask
   task automatic test_illegal_n0();
      int t, tr, p1, dn;
      logic [2:0] v;
      mode = 0;
      // inject from the first N0 cycle for three cycles
      accept_one(1'b1, 1'b0, t);
      watch(t, 40, S + 2, S + 5, tr, v, p1, dn);
      total++; if (p1 !== 0) begin bad++; $display("FAIL illegal_d1_entered got=%0d want=0", p1); end
      total++; if (tr !== t + S + 5 + S + 1) begin bad++; $display("FAIL illegal_time got=%0d want=%0d", tr, t + S + 5 + S + 1); end
      total++; if (v !== 3'b001) begin bad++; $display("FAIL illegal_rsp got=%b want=001", v); end
   endtask
   task automatic test_reset_mid();
      int t, tr, p1, dn, n;
      logic [2:0] v;
      mode = 0;
      accept_one(1'b0, 1'b1, t);
      n = 0;
      do begin
         @(negedge clk);
         b.cmd_valid = 1'b0;
         n++;
      end while (!b.PH1_t && n < 30);
      total++; if (b.PH1_t !== 1'b1) begin bad++; $display("FAIL rstmid_reach_d1 got=%b want=1", b.PH1_t); end
      rst = 1'b1;
      @(negedge clk);
      total++; if (rails !== 8'h00 || b.busy !== 1'b0) begin bad++; $display("FAIL rstmid_null got=%b busy=%b want=0 busy=0", rails, b.busy); end
      total++; if (b.rsp_valid !== 1'b0 || b.cmd_ready !== 1'b0) begin
         bad++; $display("FAIL rstmid_rsp_ready got=%b%b want=00", b.rsp_valid, b.cmd_ready);
      end
      rst = 1'b0;
      #1;
      total++; if (b.cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", b.cmd_ready); end
      watch(t, 20, -1, -1, tr, v, p1, dn);
      total++; if (tr !== -1 || dn !== 0) begin bad++; $display("FAIL rstmid_quiet got=rsp:%0d drv:%0d want=rsp:-1 drv:0", tr, dn); end
   endtask
   task automatic test_random();
      int n = 12;
      mode = 0;
      cmd_q.delete();
      for (int i = 0; i < n; i++) cmd_q.push_back(2'($urandom));
      drive_stream(3, 400);
      total++; if (rsp_t.size() !== n || acc_q.size() !== n) begin
         bad++; $display("FAIL rand_count got=%0d/%0d want=%0d", rsp_t.size(), acc_q.size(), n);
      end
      for (int i = 0; i < n && i < rsp_t.size() && i < acc_q.size(); i++) begin
         total++; if (rsp_v[i] !== {cmd_q[i], 1'b0}) begin
            bad++; $display("FAIL rand_rsp[%0d] got=%b want=%b", i, rsp_v[i], {cmd_q[i], 1'b0});
         end
         total++; if (rsp_t[i] !== acc_q[i] + LAT) begin
            bad++; $display("FAIL rand_time[%0d] got=%0d want=%0d", i, rsp_t[i], acc_q[i] + LAT);
         end
      end
   endtask
   initial begin
      b.cmd_valid = 1'b0;
      b.cmd_rd    = 1'b0;
      b.cmd_ld    = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_bad_phase0();
      test_timeout();
      test_illegal_n0();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
